// File: rtl/bus_demux_rx_if.sv
// bus_demux_rx_if
// Bundles the shared receive bus and both demultiplexed output channels.
//   bus_data/bus_sel/bus_valid -> word, routing tag (1 = ch1, 0 = ch2), qualifier
//   bus_ready                  <- selected channel has room this cycle
//   chN_data/chN_valid         <- head word of channel N FIFO, FIFO non-empty
//   chN_ready                  -> consumer of channel N takes the head
//   chN_count                  <- occupancy of channel N FIFO
// master = bus driver + channel consumers, slave = the demux itself.
interface bus_demux_rx_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] bus_data;
  logic             bus_sel;
  logic             bus_valid;
  logic             bus_ready;
  logic [WIDTH-1:0] ch1_data;
  logic             ch1_valid;
  logic             ch1_ready;
  logic [WIDTH-1:0] ch2_data;
  logic             ch2_valid;
  logic             ch2_ready;
  logic [CW-1:0]    ch1_count;
  logic [CW-1:0]    ch2_count;

  modport master (
    output bus_data, bus_sel, bus_valid, ch1_ready, ch2_ready,
    input  bus_ready, ch1_data, ch1_valid, ch2_data, ch2_valid,
    input  ch1_count, ch2_count
  );

  modport slave (
    input  bus_data, bus_sel, bus_valid, ch1_ready, ch2_ready,
    output bus_ready, ch1_data, ch1_valid, ch2_data, ch2_valid,
    output ch1_count, ch2_count
  );
endinterface

// File: rtl/bus_demux_rx.sv
// bus_demux_rx
// Far end of a 2:1 shared bus: steers each accepted word into one of two
// show-ahead FIFOs according to bus_sel and presents each FIFO on its own
// valid/ready channel.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : bus_demux_rx_if slave modport (shared bus + ch1/ch2 channels)
//
// Handshake rule on every port: a transfer happens at a rising edge exactly
// when valid and ready are both 1; valid never waits on ready, and ready here
// never looks at valid (bus_ready depends only on rst, bus_sel and the
// registered occupancy of the selected FIFO).
module bus_demux_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  bus_demux_rx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Index 0 is channel 1, index 1 is channel 2.
  logic [AW-1:0]    wptr_q [2];
  logic [AW-1:0]    wptr_d [2];
  logic [AW-1:0]    rptr_q [2];
  logic [AW-1:0]    rptr_d [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  logic [WIDTH-1:0] mem_q  [2][DEPTH];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] cons_ready;
  logic       sel_idx;
  logic       bus_ready_int;

  always_comb begin
    full          = '0;
    empty         = '0;
    push          = '0;
    pop           = '0;
    cons_ready    = {bus.ch2_ready, bus.ch1_ready};
    sel_idx       = ~bus.bus_sel;
    bus_ready_int = 1'b0;
    for (int c = 0; c < 2; c++) begin
      full[c]  = (cnt_q[c] == CW'(DEPTH));
      empty[c] = (cnt_q[c] == '0);
    end
    // Registered full only: a pop this cycle does not reopen the bus until
    // the count has actually dropped.
    bus_ready_int = !rst && !full[sel_idx];
    for (int c = 0; c < 2; c++) begin
      push[c]   = bus.bus_valid && bus_ready_int && (sel_idx == 1'(c));
      pop[c]    = !empty[c] && cons_ready[c];
      wptr_d[c] = wptr_q[c] + AW'(push[c]);
      rptr_d[c] = rptr_q[c] + AW'(pop[c]);
      cnt_d[c]  = cnt_q[c];
      if (push[c] && !pop[c]) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end else if (pop[c] && !push[c]) begin
        cnt_d[c] = cnt_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end else begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

  // Storage is deliberately not reset; the counts alone decide what is live.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem_q[c][wptr_q[c]] <= bus.bus_data;
      end
    end
  end

  assign bus.bus_ready = bus_ready_int;
  assign bus.ch1_valid = !empty[0];
  assign bus.ch2_valid = !empty[1];
  // Head word is masked to 0 while the FIFO is empty so stale entries never leak.
  assign bus.ch1_data  = empty[0] ? '0 : mem_q[0][rptr_q[0]];
  assign bus.ch2_data  = empty[1] ? '0 : mem_q[1][rptr_q[1]];
  assign bus.ch1_count = cnt_q[0];
  assign bus.ch2_count = cnt_q[1];
endmodule

// File: tb/tb_bus_demux_rx.sv
module tb_bus_demux_rx;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_demux_rx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

  bus_demux_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per channel, updated from the handshake rules.
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];

  function automatic logic model_ready();
    if (rst) return 1'b0;
    if (bif.bus_sel) return (q1.size() < DEPTH);
    return (q2.size() < DEPTH);
  endfunction

  // Advance one clock, applying the model's view of that edge; outputs are
  // then sampled 1ns after the edge.
  task automatic tick();
    logic do_push, pop1, pop2;
    do_push = bif.bus_valid && model_ready();
    pop1    = (q1.size() > 0) && bif.ch1_ready;
    pop2    = (q2.size() > 0) && bif.ch2_ready;
    @(posedge clk);
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      if (pop1) void'(q1.pop_front());
      if (pop2) void'(q2.pop_front());
      if (do_push) begin
        if (bif.bus_sel) q1.push_back(bif.bus_data);
        else             q2.push_back(bif.bus_data);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bif.bus_data  = '0;
    bif.bus_sel   = 1'b0;
    bif.bus_valid = 1'b0;
    bif.ch1_ready = 1'b0;
    bif.ch2_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bif.bus_valid = 1'b1;
    bif.bus_sel   = 1'b1;
    tick();
    tick();
    n_tests++;
    if (bif.bus_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus_ready_in_rst got=%b exp=0", bif.bus_ready);
    end
    idle_inputs();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({bif.ch1_valid, bif.ch2_valid, bif.ch1_count, bif.ch2_count} !== '0) begin
      n_fail++; $display("FAIL reset_state got v1=%b v2=%b c1=%0d c2=%0d exp all 0",
                         bif.ch1_valid, bif.ch2_valid, bif.ch1_count, bif.ch2_count);
    end
    n_tests++;
    if ({bif.ch1_data, bif.ch2_data} !== '0) begin
      n_fail++; $display("FAIL reset_data got d1=%h d2=%h exp 0", bif.ch1_data, bif.ch2_data);
    end
    n_tests++;
    if (bif.bus_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_bus_ready_after got=%b exp=1", bif.bus_ready);
    end
  endtask

  task automatic test_basic_routing();
    do_reset();
    bif.bus_valid = 1'b1;
    bif.bus_sel   = 1'b1;
    bif.bus_data  = 4'h4;
    #1;
    n_tests++;
    if (bif.ch1_valid !== 1'b0) begin
      n_fail++; $display("FAIL route_no_bypass got ch1_valid=%b exp=0", bif.ch1_valid);
    end
    tick();
    bif.bus_sel  = 1'b0;
    bif.bus_data = 4'h3;
    #1;
    n_tests++;
    if (bif.ch1_valid !== 1'b1 || bif.ch1_data !== 4'h4 || bif.ch1_count !== CW'(1)
        || bif.ch2_valid !== 1'b0) begin
      n_fail++; $display("FAIL route_ch1 got v=%b d=%h c=%0d v2=%b exp v=1 d=4 c=1 v2=0",
                         bif.ch1_valid, bif.ch1_data, bif.ch1_count, bif.ch2_valid);
    end
    tick();
    bif.bus_valid = 1'b0;
    n_tests++;
    if (bif.ch2_valid !== 1'b1 || bif.ch2_data !== 4'h3 || bif.ch2_count !== CW'(1)
        || bif.ch1_count !== CW'(1)) begin
      n_fail++; $display("FAIL route_ch2 got v=%b d=%h c=%0d c1=%0d exp v=1 d=3 c=1 c1=1",
                         bif.ch2_valid, bif.ch2_data, bif.ch2_count, bif.ch1_count);
    end
  endtask

  // Fill/block, then drain with wrap (scenarios continue from each other).
  task automatic test_fill_drain_wrap();
    logic [WIDTH-1:0] fill_words[4];
    logic [WIDTH-1:0] sent[$];
    int pushed;
    fill_words[0] = 4'h0; fill_words[1] = 4'h1; fill_words[2] = 4'hF; fill_words[3] = 4'h5;
    do_reset();
    bif.bus_valid = 1'b1;
    bif.bus_sel   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bif.bus_data = fill_words[i];
      tick();
    end
    bif.bus_data = 4'hA;
    #1;
    n_tests++;
    if (bif.ch1_count !== CW'(4) || bif.bus_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_block got c1=%0d rdy=%b exp c1=4 rdy=0", bif.ch1_count, bif.bus_ready);
    end
    tick();
    n_tests++;
    if (bif.ch1_count !== CW'(4)) begin
      n_fail++; $display("FAIL fill_no_overflow got c1=%0d exp=4", bif.ch1_count);
    end
    bif.bus_sel  = 1'b0;
    bif.bus_data = 4'hF;
    #1;
    n_tests++;
    if (bif.bus_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_ch2_open got rdy=%b exp=1", bif.bus_ready);
    end
    tick();
    bif.bus_valid = 1'b0;
    n_tests++;
    if (bif.ch2_valid !== 1'b1 || bif.ch2_data !== 4'hF || bif.ch2_count !== CW'(1)) begin
      n_fail++; $display("FAIL fill_ch2_push got v=%b d=%h c=%0d exp v=1 d=f c=1",
                         bif.ch2_valid, bif.ch2_data, bif.ch2_count);
    end
    // Drain in order on consecutive cycles.
    bif.ch1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bif.ch1_valid !== 1'b1 || bif.ch1_data !== fill_words[i]) begin
        n_fail++; $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h",
                           i, bif.ch1_valid, bif.ch1_data, fill_words[i]);
      end
      tick();
    end
    n_tests++;
    if (bif.ch1_valid !== 1'b0 || bif.ch1_data !== '0) begin
      n_fail++; $display("FAIL drain_empty got v=%b d=%h exp v=0 d=0", bif.ch1_valid, bif.ch1_data);
    end
    // Six more words across the pointer wrap while draining at random.
    pushed = 0;
    bif.bus_sel = 1'b1;
    for (int cyc = 0; cyc < 40 && (pushed < 6 || sent.size() > 0); cyc++) begin
      bif.bus_valid = (pushed < 6) && ($urandom_range(0, 3) != 0);
      bif.bus_data  = WIDTH'($urandom);
      bif.ch1_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bif.ch1_valid && bif.ch1_ready) begin
        n_tests++;
        if (sent.size() == 0 || bif.ch1_data !== sent[0]) begin
          n_fail++; $display("FAIL wrap_order got d=%h exp=%h", bif.ch1_data,
                             (sent.size() > 0) ? sent[0] : 4'h0);
        end
        if (sent.size() > 0) void'(sent.pop_front());
      end
      if (bif.bus_valid && bif.bus_ready) begin
        sent.push_back(bif.bus_data);
        pushed++;
      end
      tick();
    end
    n_tests++;
    if (pushed != 6 || sent.size() != 0) begin
      n_fail++; $display("FAIL wrap_done got pushed=%0d pending=%0d exp 6/0", pushed, sent.size());
    end
    idle_inputs();
  endtask

  task automatic test_simul_push_pop();
    logic [WIDTH-1:0] sent[$];
    do_reset();
    bif.bus_valid = 1'b1;
    bif.bus_sel   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bif.bus_data = WIDTH'($urandom);
      sent.push_back(bif.bus_data);
      tick();
    end
    bif.ch2_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bif.bus_data = WIDTH'($urandom);
      sent.push_back(bif.bus_data);
      #1;
      n_tests++;
      if (bif.ch2_count !== CW'(2) || bif.ch2_data !== sent[0]) begin
        n_fail++; $display("FAIL simul_%0d got c2=%0d d=%h exp c2=2 d=%h",
                           i, bif.ch2_count, bif.ch2_data, sent[0]);
      end
      void'(sent.pop_front());
      tick();
    end
    n_tests++;
    if (bif.ch2_count !== CW'(2)) begin
      n_fail++; $display("FAIL simul_final_count got=%0d exp=2", bif.ch2_count);
    end
    idle_inputs();
  endtask

  task automatic test_full_pop();
    do_reset();
    bif.bus_valid = 1'b1;
    bif.bus_sel   = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bif.bus_data = WIDTH'(i + 8);
      tick();
    end
    bif.ch1_ready = 1'b1;
    bif.bus_data  = 4'hC;
    #1;
    n_tests++;
    if (bif.bus_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_ready got=%b exp=0", bif.bus_ready);
    end
    tick();
    bif.ch1_ready = 1'b0;
    #1;
    n_tests++;
    if (bif.ch1_count !== CW'(3) || bif.bus_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_pop_count got c1=%0d rdy=%b exp c1=3 rdy=1",
                         bif.ch1_count, bif.bus_ready);
    end
    tick();
    bif.bus_valid = 1'b0;
    n_tests++;
    if (bif.ch1_count !== CW'(4) || q1.size() != 4 || q1[3] !== 4'hC) begin
      n_fail++; $display("FAIL full_pop_accept got c1=%0d exp=4", bif.ch1_count);
    end
    // Drain and confirm contents match the model: 9, A, B, C.
    bif.ch1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bif.ch1_data !== WIDTH'(i + 9)) begin
        n_fail++; $display("FAIL full_pop_drain_%0d got=%h exp=%h", i, bif.ch1_data, WIDTH'(i + 9));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bif.bus_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bif.bus_sel  = i[0];
      bif.bus_data = WIDTH'(i + 1);
      tick();
    end
    rst = 1'b1;
    bif.bus_sel = 1'b1;
    #1;
    n_tests++;
    if (bif.bus_ready !== 1'b0 || bif.ch1_count !== CW'(2) || bif.ch2_count !== CW'(2)) begin
      n_fail++; $display("FAIL midrst_during got rdy=%b c1=%0d c2=%0d exp rdy=0 c=2/2",
                         bif.bus_ready, bif.ch1_count, bif.ch2_count);
    end
    tick();
    rst = 1'b0;
    bif.bus_valid = 1'b0;
    #1;
    n_tests++;
    if ({bif.ch1_count, bif.ch2_count, bif.ch1_valid, bif.ch2_valid, bif.ch1_data, bif.ch2_data} !== '0
        || bif.bus_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_after got c1=%0d c2=%0d v=%b%b d=%h/%h rdy=%b exp all 0, rdy=1",
                         bif.ch1_count, bif.ch2_count, bif.ch1_valid, bif.ch2_valid,
                         bif.ch1_data, bif.ch2_data, bif.bus_ready);
    end
    bif.ch1_ready = 1'b1;
    bif.ch2_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if (bif.ch1_valid !== 1'b0 || bif.ch2_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_reappear got v1=%b v2=%b exp 0", bif.ch1_valid, bif.ch2_valid);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] e1, e2;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bif.bus_valid = ($urandom_range(0, 3) != 0);
      bif.bus_sel   = 1'($urandom);
      bif.bus_data  = WIDTH'($urandom);
      bif.ch1_ready = ($urandom_range(0, 2) == 0);
      bif.ch2_ready = ($urandom_range(0, 1) == 0);
      #1;
      e1 = (q1.size() > 0) ? q1[0] : '0;
      e2 = (q2.size() > 0) ? q2[0] : '0;
      n_tests++;
      if (bif.bus_ready !== model_ready()) begin
        n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bif.bus_ready, model_ready());
      end
      n_tests++;
      if (bif.ch1_count !== CW'(q1.size()) || bif.ch1_valid !== (q1.size() > 0) || bif.ch1_data !== e1) begin
        n_fail++; $display("FAIL rand_ch1 cyc=%0d got c=%0d v=%b d=%h exp c=%0d d=%h",
                           cyc, bif.ch1_count, bif.ch1_valid, bif.ch1_data, q1.size(), e1);
      end
      n_tests++;
      if (bif.ch2_count !== CW'(q2.size()) || bif.ch2_valid !== (q2.size() > 0) || bif.ch2_data !== e2) begin
        n_fail++; $display("FAIL rand_ch2 cyc=%0d got c=%0d v=%b d=%h exp c=%0d d=%h",
                           cyc, bif.ch2_count, bif.ch2_valid, bif.ch2_data, q2.size(), e2);
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_routing();
    test_fill_drain_wrap();
    test_simul_push_pop();
    test_full_pop();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_demux_rx.md
Name: bus_demux_rx

Overview:
- Receive-side counterpart of the 2:1 bus selector.
- Takes one shared WIDTH-bit bus plus its 1-bit select tag and steers each accepted word into one of two per-channel FIFOs.
- Each FIFO is presented on an independent valid/ready output channel.
- Sits at the far end of the shared bus and restores the two original streams with backpressure.

Parameters:
- WIDTH, 4, data width of the shared bus and of both output channels.
- DEPTH, 4, entries per channel FIFO; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_data  input  WIDTH  shared bus word.
- bus_sel  input  1  routing tag; 1 = channel 1, 0 = channel 2.
- bus_valid  input  1  bus_data/bus_sel are valid this cycle.
- bus_ready  output  1  selected channel can accept this cycle.
- ch1_data  output  WIDTH  channel 1 head word.
- ch1_valid  output  1  channel 1 FIFO non-empty.
- ch1_ready  input  1  channel 1 consumer accepts head.
- ch2_data  output  WIDTH  channel 2 head word.
- ch2_valid  output  1  channel 2 FIFO non-empty.
- ch2_ready  input  1  channel 2 consumer accepts head.
- ch1_count  output  log2(DEPTH)+1  channel 1 occupancy.
- ch2_count  output  log2(DEPTH)+1  channel 2 occupancy.

Behaviour:
- **Reset:** while rst=1 at a rising edge, all pointers, counts and valids clear to 0. bus_ready is forced 0 during any cycle rst=1. chN_data reads 0 whenever chN_valid=0. FIFO storage is not reset.
- **Reset mid-operation:** all buffered words are discarded. The first post-reset cycle shows empty FIFOs and bus_ready=1.
- **bus_ready:** combinational. Equals !rst && !full(selected channel), where the selected channel is channel 1 if bus_sel=1, else channel 2. It does not depend on bus_valid.
- **Push:** occurs when bus_valid && bus_ready at an edge. The word is written at the write pointer of the selected FIFO only; the other FIFO is untouched.
- **Pop:** occurs when chN_valid && chN_ready at an edge; the read pointer advances.
- **Output timing:** show-ahead. chN_data is always the head entry.
  - A word pushed into an empty FIFO at edge k appears with chN_valid=1 in the cycle after edge k. Latency is 1 cycle.
  - There is no same-cycle bypass from bus to channel.
- **Pointers:** log2(DEPTH) bits, wrap modulo DEPTH. The count is tracked separately. full = (count==DEPTH), empty = (count==0).
- **Simultaneous push and pop, same channel, non-empty and not full:** both occur and the count is unchanged.
- **Full channel with pop in the same cycle:** bus_ready stays 0 because it is driven from registered full only. No push that cycle; the count decrements.
- **Empty channel:** no pop is possible because valid=0.
- **Channel independence:** channels never block each other. A full channel 1 does not stall sel=0 traffic.
- **Counts:** count +1 on push-only, -1 on pop-only, unchanged otherwise. Never exceeds DEPTH; never underflows.
- **Ordering:** per-channel FIFO order is preserved. Relative order across channels is not tracked.

Test Plan:
1. **Basic routing.** After reset, drive (4'h4, sel=1) then (4'h3, sel=0), valid=1, both chN_ready=0.
   - ch1_valid=1, ch1_data=4'h4, ch1_count=1.
   - ch2_valid=1, ch2_data=4'h3, ch2_count=1.
   - Each appears one cycle after its push.
2. **Fill and block.** With ch1_ready=0, push 4'h0, 4'h1, 4'hF, 4'h5 at sel=1.
   - ch1_count=4 and bus_ready=0 while sel=1.
   - Switching sel=0 gives bus_ready=1 immediately; a 4'hF push lands in channel 2.
3. **Drain order and wrap.** Continue from scenario 2 and set ch1_ready=1.
   - Outputs 4'h0, 4'h1, 4'hF, 4'h5 on consecutive cycles, then ch1_valid=0.
   - Push 6 more words while draining; all come out in order across the pointer wrap.
4. **Simultaneous push/pop.** With ch2 at count=2 and ch2_ready=1, push to sel=0 every cycle for 5 cycles.
   - ch2_count holds at 2.
   - Data emerges in push order.
5. **Full plus pop.** With ch1 full, set ch1_ready=1 and bus_valid=1, sel=1 in the same cycle.
   - No push that cycle; count becomes 3.
   - bus_ready=1 on the next cycle, and that push is accepted.
6. **Mid-stream reset.** With both FIFOs at count 2, assert rst for 1 cycle while bus_valid=1.
   - bus_ready=0 during rst, and no push occurs.
   - Afterwards both counts are 0 and both valids are 0; data reads 0 and the old words never reappear.
